// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Half-period values assume the 50 MHz board clock.
package clk_div_pkg;

    localparam int unsigned CLK_HZ     = 50_000_000;
    localparam int unsigned HALF_1HZ   = 24_999_999;
    localparam int unsigned HALF_500HZ = 49_999;
    localparam int unsigned HALF_2HZ   = 12_499_999;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_TICK   = 1'b1
    } mode_e;

    // Half-period register value that gives a square output of hz.
    function automatic int unsigned half_for_hz(input int unsigned hz);
        return CLK_HZ / (2 * hz) - 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow half-period pair and the
// square/tick output stage. All outputs come straight from flops.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int          CNT_W    = 26,
    parameter int unsigned DEF_HALF = HALF_1HZ
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_mode,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_val,
    input  logic             i_sync,
    output logic             o_clk,
    output logic             o_tick
);

    localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEF_HALF);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_active;
    logic [CNT_W-1:0] r_shadow;
    logic             r_clk;
    logic             r_tick;

    logic             w_term;
    logic [CNT_W-1:0] w_shadow_nx;
    mode_e            w_mode;

    assign w_mode      = mode_e'(i_mode);
    assign w_term      = (r_cnt == r_active);
    // A write coinciding with sync must reach active in the same edge.
    assign w_shadow_nx = i_load ? i_val : r_shadow;

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_shadow <= RST_HALF;
        end else if (i_load) begin
            r_shadow <= i_val;
        end
    end

    // Priority: sync, then disable, then terminal count, then counting.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_active <= RST_HALF;
            r_clk    <= 1'b0;
            r_tick   <= 1'b0;
        end else if (i_sync) begin
            r_cnt    <= '0;
            r_active <= w_shadow_nx;
            r_clk    <= 1'b0;
            r_tick   <= 1'b0;
        end else if (!i_en) begin
            r_cnt    <= '0;
            r_active <= r_shadow;
            r_clk    <= 1'b0;
            r_tick   <= 1'b0;
        end else if (w_term) begin
            // Reload only here so a new value never cuts a half-period short.
            r_cnt    <= '0;
            r_active <= r_shadow;
            r_tick   <= 1'b1;
            r_clk    <= (w_mode == MODE_TICK) ? 1'b1 : ~r_clk;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_tick <= 1'b0;
            if (w_mode == MODE_TICK) begin
                r_clk <= 1'b0;
            end
        end
    end

    assign o_clk  = r_clk;
    assign o_tick = r_tick;

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent programmable dividers off clk1 with shared write port
// and a global phase-sync pulse.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int          NUM_CH   = 4,
    parameter int          CNT_W    = 26,
    parameter int unsigned DEF_HALF = HALF_1HZ
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] mode,
    input  logic              div_we,
    input  logic [3:0]        div_ch,
    input  logic [CNT_W-1:0]  div_val,
    input  logic              sync,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] w_load;

    // Out-of-range div_ch matches no channel, so such writes vanish.
    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            assign w_load[g] = div_we && (div_ch == 4'(g));

            clk_div_chan #(
                .CNT_W    (CNT_W),
                .DEF_HALF (DEF_HALF)
            ) u_chan (
                .clk1   (clk1),
                .reset  (reset),
                .i_en   (en[g]),
                .i_mode (mode[g]),
                .i_load (w_load[g]),
                .i_val  (div_val),
                .i_sync (sync),
                .o_clk  (clk_out[g]),
                .o_tick (tick[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: expected tick/clk_out per edge are
// derived from the period formulas and queued before each scenario runs.
module tb_clk_div_multi;

    localparam int          NUM_CH = 4;
    localparam int          CNT_W  = 26;
    localparam int unsigned DEF_H  = 4;

    logic              clk1    = 1'b0;
    logic              reset   = 1'b1;
    logic [NUM_CH-1:0] en      = '0;
    logic [NUM_CH-1:0] mode    = '0;
    logic              div_we  = 1'b0;
    logic [3:0]        div_ch  = '0;
    logic [CNT_W-1:0]  div_val = '0;
    logic              sync    = 1'b0;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    typedef struct {
        int   k;
        int   ch;
        logic tk;
        logic co;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   h_exp[NUM_CH];

    clk_div_multi #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .DEF_HALF (DEF_H)
    ) dut (
        .clk1    (clk1),
        .reset   (reset),
        .en      (en),
        .mode    (mode),
        .div_we  (div_we),
        .div_ch  (div_ch),
        .div_val (div_val),
        .sync    (sync),
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk1 = ~clk1;

    // Square mode from a restart: terminal every h+1 edges, output toggles there.
    function automatic exp_t sq_exp(input int k, input int ch, input int h);
        exp_t e;
        int   p;
        p    = h + 1;
        e.k  = k;
        e.ch = ch;
        e.tk = (k > 0) && (k % p == 0);
        e.co = (k > 0) && ((k / p) % 2 == 1);
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk1);
        checks++;
        if (clk_out !== '0) begin
            errors++;
            $display("FAIL reset_clk_out got=%b want=0000", clk_out);
        end
        checks++;
        if (tick !== '0) begin
            errors++;
            $display("FAIL reset_tick got=%b want=0000", tick);
        end
        reset = 1'b0;
    endtask

    task automatic test_square();
        exp_t e;
        for (int k = 1; k <= 15; k++) sb.push_back(sq_exp(k, 0, DEF_H));
        en[0] = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk1);
            e = sb.pop_front();
            checks++;
            if (tick[e.ch] !== e.tk || clk_out[e.ch] !== e.co) begin
                errors++;
                $display("FAIL square k=%0d ch%0d tick=%b clk_out=%b want tick=%b clk_out=%b",
                         e.k, e.ch, tick[e.ch], clk_out[e.ch], e.tk, e.co);
            end
        end
        en[0] = 1'b0;
    endtask

    // ch1 starts on H=4; H=2 written at edge 3 applies only after edge 5.
    task automatic test_reload();
        exp_t e;
        int   nt;
        for (int k = 1; k <= 14; k++) begin
            nt   = (k < 5) ? 0 : 1 + (k - 5) / 3;
            e.k  = k;
            e.ch = 1;
            e.tk = (k >= 5) && ((k - 5) % 3 == 0);
            e.co = (nt % 2 == 1);
            sb.push_back(e);
        end
        en[1] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk1);
            e = sb.pop_front();
            checks++;
            if (tick[e.ch] !== e.tk || clk_out[e.ch] !== e.co) begin
                errors++;
                $display("FAIL reload k=%0d ch%0d tick=%b clk_out=%b want tick=%b clk_out=%b",
                         e.k, e.ch, tick[e.ch], clk_out[e.ch], e.tk, e.co);
            end
            if (k == 2) begin
                div_we  = 1'b1;
                div_ch  = 4'd1;
                div_val = CNT_W'(2);
            end
            if (k == 3) div_we = 1'b0;
        end
        en[1] = 1'b0;
    endtask

    // ch2 tick mode H=3, then H=0 lands at the terminal on edge 16.
    task automatic test_tick_mode();
        exp_t e;
        div_we  = 1'b1;
        div_ch  = 4'd2;
        div_val = CNT_W'(3);
        @(negedge clk1);
        div_we = 1'b0;
        @(negedge clk1);
        for (int k = 1; k <= 22; k++) begin
            e.k  = k;
            e.ch = 2;
            e.tk = (k <= 12) ? (k % 4 == 0) : (k >= 16);
            e.co = e.tk;
            sb.push_back(e);
        end
        mode[2] = 1'b1;
        en[2]   = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk1);
            e = sb.pop_front();
            checks++;
            if (tick[e.ch] !== e.tk || clk_out[e.ch] !== e.co) begin
                errors++;
                $display("FAIL tick_mode k=%0d ch%0d tick=%b clk_out=%b want tick=%b clk_out=%b",
                         e.k, e.ch, tick[e.ch], clk_out[e.ch], e.tk, e.co);
            end
            if (k == 12) begin
                div_we  = 1'b1;
                div_ch  = 4'd2;
                div_val = '0;
            end
            if (k == 13) div_we = 1'b0;
        end
        en[2]   = 1'b0;
        mode[2] = 1'b0;
    endtask

    // Round 0: sync lands on ch0/ch1 terminals. Round 1: sync with a ch0 write.
    task automatic test_sync();
        exp_t e;
        h_exp = '{3, 5, 7, 9};
        for (int i = 0; i < NUM_CH; i++) begin
            div_we  = 1'b1;
            div_ch  = 4'(i);
            div_val = CNT_W'(h_exp[i]);
            @(negedge clk1);
        end
        div_we = 1'b0;
        @(negedge clk1);
        en   = '1;
        mode = '0;
        repeat (11) @(negedge clk1);
        for (int r = 0; r < 2; r++) begin
            sync = 1'b1;
            if (r == 1) begin
                div_we   = 1'b1;
                div_ch   = 4'd0;
                div_val  = CNT_W'(1);
                h_exp[0] = 1;
            end
            for (int j = 0; j <= 12; j++)
                for (int c = 0; c < NUM_CH; c++) sb.push_back(sq_exp(j, c, h_exp[c]));
            for (int j = 0; j <= 12; j++) begin
                @(negedge clk1);
                if (j == 0) begin
                    sync   = 1'b0;
                    div_we = 1'b0;
                end
                for (int c = 0; c < NUM_CH; c++) begin
                    e = sb.pop_front();
                    checks++;
                    if (tick[e.ch] !== e.tk || clk_out[e.ch] !== e.co) begin
                        errors++;
                        $display("FAIL sync r=%0d k=%0d ch%0d tick=%b clk_out=%b want tick=%b clk_out=%b",
                                 r, e.k, e.ch, tick[e.ch], clk_out[e.ch], e.tk, e.co);
                    end
                end
            end
        end
    endtask

    // Write to channel 7 must leave every channel's periods untouched.
    task automatic test_bad_ch();
        exp_t e;
        sync = 1'b1;
        for (int j = 0; j <= 24; j++)
            for (int c = 0; c < NUM_CH; c++) sb.push_back(sq_exp(j, c, h_exp[c]));
        for (int j = 0; j <= 24; j++) begin
            @(negedge clk1);
            if (j == 0) begin
                sync    = 1'b0;
                div_we  = 1'b1;
                div_ch  = 4'd7;
                div_val = CNT_W'(1);
            end
            if (j == 1) div_we = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                e = sb.pop_front();
                checks++;
                if (tick[e.ch] !== e.tk || clk_out[e.ch] !== e.co) begin
                    errors++;
                    $display("FAIL bad_ch k=%0d ch%0d tick=%b clk_out=%b want tick=%b clk_out=%b",
                             e.k, e.ch, tick[e.ch], clk_out[e.ch], e.tk, e.co);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        bit   found;
        found = 1'b0;
        for (int n = 0; n < 8 && !found; n++) begin
            @(negedge clk1);
            if (clk_out[0] === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL async_wait ch0 clk_out never high within 8 cycles, got=%b want=1", clk_out[0]);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (clk_out !== '0 || tick !== '0) begin
            errors++;
            $display("FAIL async_reset clk_out=%b tick=%b want 0000/0000", clk_out, tick);
        end
        @(negedge clk1);
        for (int k = 1; k <= 10; k++) sb.push_back(sq_exp(k, 0, DEF_H));
        reset = 1'b0;
        en    = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk1);
            e = sb.pop_front();
            checks++;
            if (tick[e.ch] !== e.tk || clk_out[e.ch] !== e.co) begin
                errors++;
                $display("FAIL post_reset k=%0d ch%0d tick=%b clk_out=%b want tick=%b clk_out=%b",
                         e.k, e.ch, tick[e.ch], clk_out[e.ch], e.tk, e.co);
            end
        end
    endtask

    initial begin
        test_reset();
        test_square();
        test_reload();
        test_tick_mode();
        test_sync();
        test_bad_ch();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
